// File: rtl/fb_sched_pkg.sv
// Shared constants and state encoding for the board frame-buffer ping-pong scheduler.
package fb_sched_pkg;

    localparam int N              = 32;
    localparam int CELLS          = N * N;
    localparam int ADDR_W         = $clog2(CELLS);
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 1000000;
    localparam int WD_W           = $clog2(TIMEOUT_CYCLES);

    // Byte count value meaning "frame complete"; one bit wider than the address.
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(CELLS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PENDING,
        SWAP
    } state_t;

    localparam logic [7:0] CELL_SPACE   = 8'd32;
    localparam logic [7:0] CELL_BLOCK   = 8'd35;
    localparam logic [7:0] CELL_FALLING = 8'd70;

endpackage

// File: rtl/frame_buffer_scheduler_sync.sv
// Synchronizer for the MCU load level with single-cycle rise/fall event outputs.
module level_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Ping-pong bank scheduler between the SPI board writer and the LED matrix scanner.
// Optional idle-write watchdog enabled by defining FRAME_TIMEOUT_EN.
module frame_buffer_scheduler
    import fb_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_async,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    input  logic              scan_frame_done,
    input  logic              err_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_byte,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              swap_pulse,
    output logic              busy,
    output logic              short_frame,
    output logic              overrun,
    output logic [7:0]        drop_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_nxt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_byte;
    logic              r_rd_bank;
    logic              r_swap;
    logic              r_short;
    logic              r_overrun;
    logic [7:0]        r_drop;

    logic              w_rise;
    logic              w_fall;
    logic              w_wen_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_byte_nxt;
    logic              w_swap_nxt;
    logic              w_short_set;
    logic              w_ovr_set;
    logic              w_drop_inc;
    logic              w_timeout;

    level_sync #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (load_async),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

`ifdef FRAME_TIMEOUT_EN
    logic [WD_W-1:0] r_wd;

    // Counts idle cycles within LOAD; any received byte restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd <= '0;
        end else if (r_state != LOAD || wr_valid) begin
            r_wd <= '0;
        end else if (!w_timeout) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    assign w_timeout = (r_state == LOAD) && !wr_valid && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_wen_nxt   = 1'b0;
        w_addr_nxt  = r_wr_addr;
        w_byte_nxt  = r_wr_byte;
        w_swap_nxt  = 1'b0;
        w_short_set = 1'b0;
        w_ovr_set   = 1'b0;
        w_drop_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ovr_set = wr_valid;
                if (w_rise) begin
                    w_state_nxt = LOAD;
                    w_count_nxt = '0;
                end
            end
            LOAD: begin
                if (w_timeout) begin
                    w_state_nxt = IDLE;
                    w_short_set = 1'b1;
                end else begin
                    if (wr_valid) begin
                        if (r_count != FULL_CNT) begin
                            w_wen_nxt   = 1'b1;
                            w_addr_nxt  = r_count[ADDR_W-1:0];
                            w_byte_nxt  = wr_data;
                            w_count_nxt = r_count + 1'b1;
                        end else begin
                            w_ovr_set = 1'b1;
                        end
                    end
                    // A byte arriving with the fall still counts toward completeness.
                    if (w_fall) begin
                        if (w_count_nxt == FULL_CNT) begin
                            w_state_nxt = PENDING;
                        end else begin
                            w_state_nxt = IDLE;
                            w_short_set = 1'b1;
                        end
                    end
                end
            end
            PENDING: begin
                w_ovr_set = wr_valid;
                if (w_rise) begin
                    w_state_nxt = LOAD;
                    w_count_nxt = '0;
                    w_drop_inc  = 1'b1;
                end else if (scan_frame_done) begin
                    w_state_nxt = SWAP;
                    w_swap_nxt  = 1'b1;
                end
            end
            SWAP: begin
                w_ovr_set   = wr_valid;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Banks flip on the edge entering SWAP, so swap_pulse and the new banks appear together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_byte <= '0;
            r_rd_bank <= 1'b0;
            r_swap    <= 1'b0;
            r_short   <= 1'b0;
            r_overrun <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_wr_en   <= w_wen_nxt;
            r_wr_addr <= w_addr_nxt;
            r_wr_byte <= w_byte_nxt;
            r_rd_bank <= r_rd_bank ^ w_swap_nxt;
            r_swap    <= w_swap_nxt;
            if (w_short_set) begin
                r_short <= 1'b1;
            end else if (err_clr) begin
                r_short <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_drop_inc && r_drop != 8'hFF) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_byte     = r_wr_byte;
    assign rd_bank     = r_rd_bank;
    assign wr_bank     = ~r_rd_bank;
    assign swap_pulse  = r_swap;
    assign busy        = (r_state == LOAD) || (r_state == PENDING);
    assign short_frame = r_short;
    assign overrun     = r_overrun;
    assign drop_cnt    = r_drop;

endmodule
